// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access,
// with round-robin tie-break and a per-access ack timeout.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_done,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic [DW-1:0]   d_rdata,
    output logic            d_done,
    output logic            err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ack
);
    typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_owner_q, last_owner_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW/8-1:0] be_q, be_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;
    logic            err_q, err_d;
    logic            pick_d;

    // owner encoding: 1 = data port, 0 = fetch port; a tie goes to whoever was not served last
    assign pick_d = d_req & (~if_req | ~last_owner_q);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        cnt_d        = cnt_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        err_d        = err_q;
        case (state_q)
            IDLE: if (if_req | d_req) begin
                state_d = GRANT;
                owner_d = pick_d;
                addr_d  = pick_d ? d_addr : if_addr;
                we_d    = pick_d & d_we;
                wdata_d = pick_d ? d_wdata : '0;
                be_d    = pick_d ? d_be : '1;
                cnt_d   = '0;
            end
            GRANT: if (mem_ack || cnt_q == 8'(TIMEOUT - 1)) begin
                state_d    = RESP;
                err_d      = ~mem_ack;
                if_rdata_d = owner_q ? if_rdata_q : (mem_ack ? mem_rdata : '0);
                d_rdata_d  = owner_q ? (mem_ack ? mem_rdata : '0) : d_rdata_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            RESP: begin
                state_d      = IDLE;
                last_owner_d = owner_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            be_q         <= '0;
            cnt_q        <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            cnt_q        <= cnt_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            err_q        <= err_d;
        end
    end

    assign mem_req   = (state_q == GRANT);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign if_done   = (state_q == RESP) & ~owner_q;
    assign d_done    = (state_q == RESP) & owner_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign err       = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and random accesses
// checked against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
    localparam int TO = 16;

    logic        clk, reset;
    logic        if_req, if_done, d_req, d_we, d_done, err;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  d_be, mem_be;

    int n_chk = 0, n_fail = 0;
    logic        last_d;
    logic [31:0] m_ifr, m_dr;

    typedef struct {
        logic ir, dr, dwe;
        logic [31:0] ia, da, wd;
        logic [3:0] be;
        logic [31:0] rd;
        int w;
        logic exp_d, exp_err;
        int exp_gc;
    } vec_t;

    vec_t tbl[9];

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_done(d_done), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        last_d = 1'b0;
        m_ifr  = '0;
        m_dr   = '0;
    endtask

    // Drives one request set, plays a memory that acks after v.w wait cycles, checks the result.
    task automatic apply(input vec_t v);
        int gc = 0, lat = 0;
        logic seen = 0, bad = 0, got_d = 0;
        logic [31:0] ea, erd;
        logic [3:0] eb;
        logic ewe;
        ea  = v.exp_d ? v.da : v.ia;
        eb  = v.exp_d ? v.be : 4'hf;
        ewe = v.exp_d & v.dwe;
        erd = v.exp_err ? 32'h0 : v.rd;
        if (v.exp_d) m_dr = erd; else m_ifr = erd;
        last_d = v.exp_d;
        if_req = v.ir; d_req = v.dr; if_addr = v.ia; d_addr = v.da;
        d_we = v.dwe; d_wdata = v.wd; d_be = v.be; mem_rdata = v.rd;
        while (!seen && lat < 300) begin
            @(negedge clk);
            lat++;
            if (if_done | d_done) begin
                seen = 1; got_d = d_done; mem_ack = 0;
                if (mem_req) bad = 1;
            end else if (mem_req) begin
                if (mem_addr !== ea || mem_we !== ewe || mem_be !== eb || (ewe && mem_wdata !== v.wd)) bad = 1;
                mem_ack = (gc == v.w);
                gc++;
            end else begin
                mem_ack = 0;
            end
        end
        chk("done_seen", {31'b0, seen}, 32'd1);
        if (seen) begin
            chk("owner", {31'b0, got_d}, {31'b0, v.exp_d});
            chk("err", {31'b0, err}, {31'b0, v.exp_err});
            chk("grant_cycles", gc, v.exp_gc);
            chk("latency", lat, v.exp_gc + 1);
            chk("mem_fields", {31'b0, bad}, 32'd0);
            chk("if_rdata", if_rdata, m_ifr);
            chk("d_rdata", d_rdata, m_dr);
        end
        if_req = 0; d_req = 0;
        @(negedge clk);
        chk("done_one_cycle", {31'b0, if_done | d_done}, 32'd0);
    endtask

    function automatic vec_t mk(input logic ir, dr, dwe, input logic [31:0] ia, da, wd,
                                input logic [3:0] be, input logic [31:0] rd, input int w,
                                input logic exp_d, exp_err, input int exp_gc);
        vec_t v;
        v.ir = ir; v.dr = dr; v.dwe = dwe; v.ia = ia; v.da = da; v.wd = wd; v.be = be;
        v.rd = rd; v.w = w; v.exp_d = exp_d; v.exp_err = exp_err; v.exp_gc = exp_gc;
        return v;
    endfunction

    initial begin
        tbl[0] = mk(1, 0, 0, 32'h100, 32'h0, 32'h0, 4'h0, 32'h00500093, 0, 0, 0, 1);
        tbl[1] = mk(0, 1, 1, 32'h0, 32'h2000, 32'hDEADBEEF, 4'b0011, 32'h11111111, 2, 1, 0, 3);
        tbl[2] = mk(1, 1, 0, 32'h104, 32'h2004, 32'h0, 4'hf, 32'hA0A0A0A0, 1, 0, 0, 2);
        tbl[3] = mk(1, 1, 1, 32'h108, 32'h2008, 32'h12345678, 4'b1000, 32'hB1B1B1B1, 0, 1, 0, 1);
        tbl[4] = mk(1, 1, 0, 32'h10C, 32'h200C, 32'h0, 4'hf, 32'hC2C2C2C2, 3, 0, 0, 4);
        tbl[5] = mk(1, 0, 0, 32'h110, 32'h0, 32'h0, 4'h0, 32'hD3D3D3D3, 20, 0, 1, TO);
        tbl[6] = mk(0, 1, 0, 32'h0, 32'h3000, 32'h0, 4'hf, 32'hE4E4E4E4, TO - 1, 1, 0, TO);
        tbl[7] = mk(0, 1, 0, 32'h0, 32'h3004, 32'h0, 4'hf, 32'hF5F5F5F5, TO, 1, 1, TO);
        tbl[8] = mk(1, 1, 0, 32'h114, 32'h3008, 32'h0, 4'hf, 32'h06060606, 0, 0, 0, 1);

        reset = 0; if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0;
        d_wdata = 0; d_be = 0; mem_rdata = 0; mem_ack = 0;
        model_reset();
        #1;
        chk("rst_mem_req", {31'b0, mem_req}, 0);
        chk("rst_mem_we", {31'b0, mem_we}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_be", {28'b0, mem_be}, 0);
        chk("rst_dones", {30'b0, if_done, d_done}, 0);
        chk("rst_err", {31'b0, err}, 0);
        chk("rst_rdata", if_rdata | d_rdata, 0);
        @(negedge clk); @(negedge clk);
        reset = 1;
        @(negedge clk);

        for (int i = 0; i < 4; i++)
            apply(mk(1, 1, 0, 32'h400 + i, 32'h500 + i, 32'h0, 4'hf, 32'h7700 + i, 0, (i % 2) == 0, 0, 1));

        for (int i = 0; i < 9; i++) apply(tbl[i]);

        @(negedge clk);
        if_req = 1; if_addr = 32'h300; mem_ack = 0;
        begin
            int k = 0;
            do begin @(negedge clk); k++; end while (!mem_req && k < 10);
            chk("rst_mid_grant_reached", {31'b0, mem_req}, 1);
        end
        #2 reset = 0;
        #1;
        chk("async_mem_req", {31'b0, mem_req}, 0);
        chk("async_dones", {30'b0, if_done, d_done}, 0);
        chk("async_mem_addr", mem_addr, 0);
        chk("async_if_rdata", if_rdata, 0);
        chk("async_d_rdata", d_rdata, 0);
        model_reset();
        if_req = 0;
        @(negedge clk);
        chk("rst_held_dones", {30'b0, if_done, d_done}, 0);
        reset = 1;
        @(negedge clk);
        apply(mk(1, 0, 0, 32'h100, 32'h0, 32'h0, 4'h0, 32'h00500093, 0, 0, 0, 1));

        for (int i = 0; i < 3; i++) begin
            mem_ack = 1;
            @(negedge clk);
            chk("spurious_ack_done", {30'b0, if_done, d_done}, 0);
            chk("spurious_ack_req", {31'b0, mem_req}, 0);
        end
        mem_ack = 0;

        for (int i = 0; i < 40; i++) begin
            vec_t v;
            int sel;
            sel = $urandom_range(1, 3);
            v.ir = sel[0]; v.dr = sel[1];
            v.dwe = 1'($urandom_range(0, 1));
            v.ia = $urandom; v.da = $urandom; v.wd = $urandom; v.rd = $urandom;
            v.be = 4'($urandom_range(0, 15));
            v.w = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 3, TO + 4) : $urandom_range(0, 3);
            v.exp_d = (v.ir && v.dr) ? !last_d : v.dr;
            v.exp_err = (v.w >= TO);
            v.exp_gc = v.exp_err ? TO : v.w + 1;
            apply(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
